// File: rtl/breakout_pkg.sv
// Shared definitions for the breakout game controller: state encoding and BCD score geometry.
package breakout_pkg;

  typedef enum logic [1:0] {
    NEWGAME = 2'b00,
    PLAY    = 2'b01,
    NEWBALL = 2'b10,
    OVER    = 2'b11
  } state_t;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_DIGITS  = 4;
  localparam int SCORE_W     = BCD_DIGIT_W * BCD_DIGITS;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 16'h9999;

endpackage

// File: rtl/bcd_inc4.sv
// Combinational 4-digit packed-BCD increment that saturates at 9999.
module bcd_inc4
  import breakout_pkg::*;
(
  input  logic [SCORE_W-1:0] din,
  output logic [SCORE_W-1:0] dout
);

  // carry[gi] is set when digit gi must step; digit 0 steps unless already saturated
  logic [BCD_DIGITS-1:0] carry;

  assign carry[0] = (din != SCORE_MAX);

  for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
    logic [BCD_DIGIT_W-1:0] d;
    assign d = din[gi*BCD_DIGIT_W +: BCD_DIGIT_W];
    assign dout[gi*BCD_DIGIT_W +: BCD_DIGIT_W] =
      !carry[gi] ? d : ((d == 4'd9) ? 4'd0 : d + 4'd1);
    if (gi < BCD_DIGITS - 1) begin : g_carry
      assign carry[gi+1] = carry[gi] && (d == 4'd9);
    end
  end

endmodule

// File: rtl/breakout_ctrl.sv
// Breakout game-state controller: keypad start/serve, BCD score, balls and hold timer.
// Define BREAKOUT_CTRL_HISCORE_EN to add a high-score register shown on seg_data.
module breakout_ctrl
  import breakout_pkg::*;
#(
  parameter int         BALLS      = 3,
  parameter int         HOLD_TICKS = 120,
  parameter logic [4:0] START_KEY  = 5'h11
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  key_code,
  input  logic        key_ready,
  input  logic        frame_tick,
  input  logic        hit,
  input  logic        miss,
  output logic        gra_still,
  output logic [1:0]  state,
  output logic [1:0]  balls,
  output logic [15:0] score,
  output logic [31:0] seg_data
);

  localparam int TW = $clog2(HOLD_TICKS + 1);
  localparam logic [TW-1:0] HOLD_MAX   = TW'(HOLD_TICKS);
  localparam logic [1:0]    BALLS_INIT = 2'(BALLS);

  state_t               state_reg, state_next;
  logic                 gra_still_reg, gra_still_next;
  logic [1:0]           balls_reg, balls_next;
  logic [SCORE_W-1:0]   score_reg, score_next, score_inc;
  logic [TW-1:0]        timer_reg, timer_next, timer_inc;
  logic                 key_reg;
  logic                 press;

  bcd_inc4 u_bcd_inc4 (
    .din  (score_reg),
    .dout (score_inc)
  );

  // rising edge of the held-key level, qualified by the start code
  assign press     = key_ready && !key_reg && (key_code == START_KEY);
  assign timer_inc = (frame_tick && timer_reg != HOLD_MAX) ? timer_reg + 1'b1 : timer_reg;

  always_comb begin
    state_next = state_reg;
    balls_next = balls_reg;
    score_next = score_reg;
    timer_next = timer_reg;
    case (state_reg)
      NEWGAME: begin
        timer_next = '0;
        if (press) begin
          state_next = PLAY;
          score_next = '0;
          balls_next = BALLS_INIT;
        end
      end
      PLAY: begin
        if (hit) score_next = score_inc;
        if (miss) begin
          timer_next = '0;
          if (balls_reg > 2'd1) begin
            balls_next = balls_reg - 2'd1;
            state_next = NEWBALL;
          end else begin
            balls_next = 2'd0;
            state_next = OVER;
          end
        end
      end
      NEWBALL: begin
        timer_next = timer_inc;
        if (press || timer_reg == HOLD_MAX) state_next = PLAY;
      end
      default: begin
        timer_next = timer_inc;
        if (timer_reg == HOLD_MAX) state_next = NEWGAME;
      end
    endcase
    gra_still_next = (state_next != PLAY);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= NEWGAME;
      gra_still_reg <= 1'b1;
      balls_reg     <= BALLS_INIT;
      score_reg     <= '0;
      timer_reg     <= '0;
      key_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      gra_still_reg <= gra_still_next;
      balls_reg     <= balls_next;
      score_reg     <= score_next;
      timer_reg     <= timer_next;
      key_reg       <= key_ready;
    end
  end

`ifdef BREAKOUT_CTRL_HISCORE_EN
  logic [SCORE_W-1:0] hi_reg;

  // packed BCD orders the same as its decimal value, so a plain compare suffices
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hi_reg <= '0;
    end else if (state_reg != OVER && state_next == OVER && score_next > hi_reg) begin
      hi_reg <= score_next;
    end
  end

  assign seg_data = {hi_reg, score_reg};
`else
  assign seg_data = {14'h0, balls_reg, score_reg};
`endif

  assign state     = state_reg;
  assign gra_still = gra_still_reg;
  assign balls     = balls_reg;
  assign score     = score_reg;

endmodule

// File: doc/breakout_ctrl.md
BREAKOUT_CTRL -- requirements
Module: breakout_ctrl

Interface
REQ-001 Parameter BALLS, default 3: balls per game, range 1..3.
REQ-002 Parameter HOLD_TICKS, default 120: frame ticks spent in NEWBALL/OVER hold, range 1..255.
REQ-003 Parameter START_KEY, default 5'h11: keypad code that starts the game or serves a ball.
REQ-004 Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; asynchronous, active-low.
- key_code  in  5  keypad code, valid while key_ready=1.
- key_ready  in  1  keypad level flag; high while a key is held.
- frame_tick  in  1  one-clk pulse per video frame.
- hit  in  1  one-clk pulse, ball hit a brick.
- miss  in  1  one-clk pulse, ball lost past the paddle.
- gra_still  out  1  freezes ball motion in the graph stage.
- state  out  2  current game state.
- balls  out  2  balls remaining.
- score  out  16  4-digit packed BCD score.
- seg_data  out  32  word for the 7-segment device.

Function
REQ-005 Key press = key_ready registered once, press when key_ready=1 and its registered copy=0 and key_code==START_KEY; one press per key hold.
REQ-006 States: NEWGAME=2'b00, PLAY=2'b01, NEWBALL=2'b10, OVER=2'b11; state output = state register.
REQ-007 NEWGAME: gra_still=1; on press -> PLAY; on the same edge score=0 and balls=BALLS.
REQ-008 PLAY: gra_still=0; hit increments score by 1 in BCD, saturating at 16'h9999.
REQ-009 PLAY, miss with balls>1: balls decrements, timer clears, next state NEWBALL.
REQ-010 PLAY, miss with balls==1: balls=0, timer clears, next state OVER.
REQ-011 PLAY, hit and miss in the same cycle: both take effect; score increments and the miss transition occurs.
REQ-012 NEWBALL: gra_still=1; timer increments on frame_tick; -> PLAY on press or when timer reaches HOLD_TICKS, whichever comes first.
REQ-013 OVER: gra_still=1; timer increments on frame_tick; -> NEWGAME when timer reaches HOLD_TICKS; presses ignored.
REQ-014 hit/miss outside PLAY are ignored.
REQ-015 All outputs registered; each takes effect one clk after the causing input edge.
REQ-016 Timer width = clog2(HOLD_TICKS+1); it never wraps and holds at HOLD_TICKS.

Reset
REQ-017 rstn=0 immediately forces: state=NEWGAME, gra_still=1, balls=BALLS, score=0, timer=0, key-ready copy=0, high score=0.
REQ-018 Reset asserted mid-game in any state abandons the game with no residual event.

Configuration
REQ-019 With BREAKOUT_CTRL_HISCORE_EN defined: a 16-bit BCD high score loads score on entry to OVER when score > high score (unsigned compare of packed BCD); seg_data = {high score, score}.
REQ-020 Without BREAKOUT_CTRL_HISCORE_EN: no high-score register; seg_data = {14'h0, balls, score}.

Structure
REQ-021 A shared package breakout_pkg holds the state encoding constants and the BCD digit width.
REQ-022 One sub-module, bcd_inc4: combinational 4-digit BCD +1 with saturation at 9999.

Verification
REQ-023 Reset, then press START_KEY -> state=01, gra_still=0, balls=3, score=0.
REQ-024 In PLAY, 12 hit pulses -> score=16'h0012; score=16'h9999 plus hit -> stays 16'h9999.
REQ-025 3 miss pulses, each followed by 120 frame_ticks -> NEWBALL twice, then OVER with balls=0; after 120 more ticks -> NEWGAME.
REQ-026 In NEWBALL, START_KEY pressed after 5 ticks -> PLAY on the next clk; key held 1000 clks -> exactly one press.
REQ-027 hit and miss in the same clk with balls=1 -> score+1 and state=OVER; hit in OVER -> score unchanged.
REQ-028 With HISCORE_EN: game 1 ends at 0025, game 2 ends at 0007 -> seg_data=32'h00250007; rstn pulse in PLAY -> all REQ-017 values.
